// File: rtl/machina_pkg.sv
// Shared definitions for the perceptron neuron: FSM states, channel widths and
// the 16-bit saturating clamp used by both the forward sum and the weight update.
package machina_pkg;

  localparam int ACT_W = 8;
  localparam int ARG_W = 16;
  localparam int SAT_W = 40;

  // Raw state codes, for flows that cannot carry the enum type across a boundary.
  localparam bit         NOENUM = 1'b0;
  localparam logic [3:0] S_INP  = 4'd0;
  localparam logic [3:0] S_MAC  = 4'd1;
  localparam logic [3:0] S_ARG  = 4'd2;
  localparam logic [3:0] S_RES  = 4'd3;
  localparam logic [3:0] S_OUT  = 4'd4;
  localparam logic [3:0] S_DEL  = 4'd5;
  localparam logic [3:0] S_ERR  = 4'd6;
  localparam logic [3:0] S_FBK  = 4'd7;
  localparam logic [3:0] S_UPD  = 4'd8;

  typedef enum logic [3:0] {
    ST_INP = S_INP,
    ST_MAC = S_MAC,
    ST_ARG = S_ARG,
    ST_RES = S_RES,
    ST_OUT = S_OUT,
    ST_DEL = S_DEL,
    ST_ERR = S_ERR,
    ST_FBK = S_FBK,
    ST_UPD = S_UPD
  } state_t;

  localparam logic signed [SAT_W-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [SAT_W-1:0] SAT_MIN = -40'sd32768;

  function automatic logic signed [ARG_W-1:0] sat16(input logic signed [SAT_W-1:0] v);
    if (v > SAT_MAX) begin
      return 16'sh7FFF;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return v[ARG_W-1:0];
    end
  endfunction

endpackage

// File: rtl/perceptron_if.sv
// Channel bundle between the perceptron (master), its activation unit and the
// upstream/downstream neighbours (slave side).
interface perceptron_if
  import machina_pkg::*;
#(
  parameter int N = 4
);
  logic                 inp_valid;
  logic [ACT_W*N-1:0]   inp_data;
  logic                 inp_ready;
  logic                 arg_valid;
  logic [ARG_W-1:0]     arg_data;
  logic                 arg_ready;
  logic                 res_valid;
  logic [ACT_W-1:0]     res_data;
  logic                 res_ready;
  logic                 out_valid;
  logic [ACT_W-1:0]     out_data;
  logic                 out_ready;
  logic                 del_valid;
  logic [ARG_W-1:0]     del_data;
  logic                 del_ready;
  logic                 err_valid;
  logic [ARG_W-1:0]     err_data;
  logic                 err_ready;
  logic                 fbk_valid;
  logic [ARG_W-1:0]     fbk_data;
  logic                 fbk_ready;

  modport master (
    input  inp_valid, inp_data, output inp_ready,
    output arg_valid, arg_data, input  arg_ready,
    input  res_valid, res_data, output res_ready,
    output out_valid, out_data, input  out_ready,
    input  del_valid, del_data, output del_ready,
    output err_valid, err_data, input  err_ready,
    input  fbk_valid, fbk_data, output fbk_ready
  );

  modport slave (
    output inp_valid, inp_data, input  inp_ready,
    input  arg_valid, arg_data, output arg_ready,
    output res_valid, res_data, input  res_ready,
    input  out_valid, out_data, output out_ready,
    output del_valid, del_data, input  del_ready,
    input  err_valid, err_data, output err_ready,
    output fbk_valid, fbk_data, input  fbk_ready
  );

endinterface

// File: rtl/signed_multiply.sv
// Combinational signed 16-bit by unsigned 8-bit multiply with a full 25-bit result.
module signed_multiply
  import machina_pkg::*;
(
  input  logic signed [ARG_W-1:0]     a,
  input  logic        [ACT_W-1:0]     x,
  output logic signed [ARG_W+ACT_W:0] p
);
  localparam int PW = ARG_W + ACT_W + 1;

  logic signed [ACT_W:0] x_s;

  assign x_s = {1'b0, x};
  assign p   = PW'(a) * PW'(x_s);

endmodule

// File: rtl/perceptron.sv
// Trainable N-input neuron: serial multiply-accumulate forward pass and serial
// weight update, both sharing one multiplier through an index-selected operand mux.
module perceptron
  import machina_pkg::*;
#(
  parameter int N    = 4,
  parameter int RATE = 8
)
(
  input  logic         clock,
  input  logic         reset,
  input  logic         train,
  perceptron_if.master bus
);
  localparam int PROD_W = ARG_W + ACT_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(N);
  localparam int IDX_W  = $clog2(N + 1);
  localparam int SEL_W  = (N > 1) ? $clog2(N) : 1;

  state_t                   state_reg;
  logic signed [ARG_W-1:0]  weight_reg [N];
  logic        [ACT_W-1:0]  x_reg [N];
  logic        [ACT_W-1:0]  x_in [N];
  logic signed [ACC_W-1:0]  acc_reg;
  logic        [IDX_W-1:0]  idx_reg;
  logic signed [ARG_W-1:0]  delta_reg;
  logic                     arg_valid_reg;
  logic                     out_valid_reg;
  logic                     err_valid_reg;
  logic        [ARG_W-1:0]  arg_data_reg;
  logic        [ACT_W-1:0]  out_data_reg;
  logic        [ARG_W-1:0]  err_data_reg;

  logic        [SEL_W-1:0]  sel_idx;
  logic signed [ARG_W-1:0]  mul_a;
  logic        [ACT_W-1:0]  mul_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] incr;
  logic signed [SAT_W-1:0]  upd_sum;
  logic                     mac_done;
  logic                     upd_last;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign x_in[gi] = bus.inp_data[ACT_W*gi +: ACT_W];
  end

  // idx reaches N on the final MAC cycle; clamp so the mux never indexes past the array.
  assign sel_idx  = (idx_reg < IDX_W'(N)) ? SEL_W'(idx_reg) : '0;
  assign mul_a    = (state_reg == ST_UPD) ? delta_reg : weight_reg[sel_idx];
  assign mul_x    = x_reg[sel_idx];
  assign incr     = prod >>> RATE;
  assign upd_sum  = SAT_W'(weight_reg[sel_idx]) + SAT_W'(incr);
  assign mac_done = (idx_reg == IDX_W'(N));
  assign upd_last = (idx_reg == IDX_W'(N - 1));

  signed_multiply u_mul (
    .a (mul_a),
    .x (mul_x),
    .p (prod)
  );

  assign bus.inp_ready = (state_reg == ST_INP);
  assign bus.res_ready = (state_reg == ST_RES);
  assign bus.del_ready = (state_reg == ST_DEL);
  assign bus.fbk_ready = (state_reg == ST_FBK);
  assign bus.arg_valid = arg_valid_reg;
  assign bus.arg_data  = arg_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.err_valid = err_valid_reg;
  assign bus.err_data  = err_data_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_INP;
      acc_reg       <= '0;
      idx_reg       <= '0;
      delta_reg     <= '0;
      arg_valid_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      err_valid_reg <= 1'b0;
      arg_data_reg  <= '0;
      out_data_reg  <= '0;
      err_data_reg  <= '0;
      for (int i = 0; i < N; i++) begin
        weight_reg[i] <= '0;
        x_reg[i]      <= '0;
      end
    end else begin
      unique case (state_reg)
        ST_INP: begin
          if (bus.inp_valid) begin
            for (int i = 0; i < N; i++) begin
              x_reg[i] <= x_in[i];
            end
            acc_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= ST_MAC;
          end
        end
        ST_MAC: begin
          // N accumulate cycles, then one more to clamp and present the sum.
          if (mac_done) begin
            arg_data_reg  <= sat16(SAT_W'(acc_reg));
            arg_valid_reg <= 1'b1;
            state_reg     <= ST_ARG;
          end else begin
            acc_reg <= acc_reg + ACC_W'(prod);
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        ST_ARG: begin
          if (bus.arg_ready) begin
            arg_valid_reg <= 1'b0;
            state_reg     <= ST_RES;
          end
        end
        ST_RES: begin
          if (bus.res_valid) begin
            out_data_reg  <= bus.res_data;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= train ? ST_DEL : ST_INP;
          end
        end
        ST_DEL: begin
          if (bus.del_valid) begin
            err_data_reg  <= bus.del_data;
            err_valid_reg <= 1'b1;
            state_reg     <= ST_ERR;
          end
        end
        ST_ERR: begin
          if (bus.err_ready) begin
            err_valid_reg <= 1'b0;
            state_reg     <= ST_FBK;
          end
        end
        ST_FBK: begin
          if (bus.fbk_valid) begin
            delta_reg <= bus.fbk_data;
            idx_reg   <= '0;
            state_reg <= ST_UPD;
          end
        end
        ST_UPD: begin
          weight_reg[sel_idx] <= sat16(upd_sum);
          idx_reg             <= idx_reg + IDX_W'(1);
          if (upd_last) begin
            state_reg <= ST_INP;
          end
        end
        default: state_reg <= ST_INP;
      endcase
    end
  end

endmodule
